mac_tree_acc: RTL

Parametrised, fully pipelined N-lane multiply-accumulate engine with a registered adder tree and a saturating output accumulator. Each cycle it takes one vector of `lanes` activation/weight pairs and reduces it to a single partial sum. Vectors tagged first/last are accumulated across cycles into one result, seeded by an incoming partial sum. It is the next-generation dot-product unit for the PE/column datapath and replaces the fixed 4-lane combinational multiply-add-tree wrapper.

---
 rtl/mac_tree_acc.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/mac_tree_acc.sv
// Pipelined N-lane multiply-accumulate: per-lane products, registered adder tree,
// saturating accumulator with first/last framing and protocol-error reporting.
module mac_tree_acc #(
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter int lanes   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic                  first_in,
    input  logic                  last_in,
    input  logic [lanes*bw-1:0]   x,
    input  logic [lanes*bw-1:0]   w,
    input  logic [psum_bw-1:0]    psum_in,
    output logic [psum_bw-1:0]    out,
    output logic                  out_valid,
    output logic                  ovf,
    output logic                  err,
    output logic                  busy
);

    localparam int K  = $clog2(lanes);
    localparam int PW = 2 * bw;
    localparam int AW = psum_bw + 1;

    typedef enum logic {IDLE, ACC} state_t;

    // Control sideband: index 0 is the multiply stage, index K-1 feeds the accumulator.
    logic [K-1:0]       v_q, f_q, l_q;
    logic [psum_bw-1:0] ps_q [K];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q <= '0;
            f_q <= '0;
            l_q <= '0;
            for (int unsigned i = 0; i < K; i++) ps_q[i] <= '0;
        end else begin
            v_q[0]  <= valid_in;
            f_q[0]  <= valid_in & first_in;
            l_q[0]  <= valid_in & last_in;
            ps_q[0] <= psum_in;
            for (int unsigned i = 1; i < K; i++) begin
                v_q[i]  <= v_q[i-1];
                f_q[i]  <= f_q[i-1];
                l_q[i]  <= l_q[i-1];
                ps_q[i] <= ps_q[i-1];
            end
        end
    end

    // The final tree level is combinational into the accumulator so that the
    // vector-to-result latency is log2(lanes)+1 register stages.
    for (genvar j = 0; j <= K; j++) begin : g_lvl
        localparam int N = lanes >> j;
        localparam int W = PW + j;
        logic signed [W-1:0] lvl [N];

        if (j == 0) begin : g_mul
            logic signed [PW-1:0] prod [N];
            always_comb begin
                for (int unsigned n = 0; n < N; n++)
                    prod[n] = PW'($signed({1'b0, x[n*bw +: bw]})) * PW'($signed(w[n*bw +: bw]));
            end
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int unsigned n = 0; n < N; n++) lvl[n] <= '0;
                end else begin
                    for (int unsigned n = 0; n < N; n++) lvl[n] <= prod[n];
                end
            end
        end else begin : g_add
            logic signed [W-1:0] nxt [N];
            always_comb begin
                for (int unsigned n = 0; n < N; n++)
                    nxt[n] = W'(g_lvl[j-1].lvl[2*n]) + W'(g_lvl[j-1].lvl[2*n+1]);
            end
            if (j < K) begin : g_reg
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        for (int unsigned n = 0; n < N; n++) lvl[n] <= '0;
                    end else begin
                        for (int unsigned n = 0; n < N; n++) lvl[n] <= nxt[n];
                    end
                end
            end else begin : g_comb
                always_comb begin
                    for (int unsigned n = 0; n < N; n++) lvl[n] = nxt[n];
                end
            end
        end
    end

    state_t             state_q, state_d;
    logic [psum_bw-1:0] acc_q, acc_d;
    logic               sat_q, sat_d;
    logic [psum_bw-1:0] out_q, out_d;
    logic               out_valid_q, out_valid_d;
    logic               ovf_q, ovf_d;
    logic               err_q, err_d;

    logic                va, fa, la;
    logic signed [AW-1:0] tree_ext, base, sum;
    logic                clip;
    logic [psum_bw-1:0]  sat_val;
    logic                accept;

    assign va = v_q[K-1];
    assign fa = f_q[K-1];
    assign la = l_q[K-1];

    always_comb begin
        tree_ext = AW'(g_lvl[K].lvl[0]);
        base     = fa ? AW'($signed(ps_q[K-1])) : AW'($signed(acc_q));
        sum      = base + tree_ext;
        // One guard bit: a mismatch between the top two bits means the result left range.
        clip     = sum[AW-1] ^ sum[AW-2];
        if (clip)
            sat_val = sum[AW-1] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
        else
            sat_val = sum[psum_bw-1:0];
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        sat_d       = sat_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        ovf_d       = 1'b0;
        err_d       = 1'b0;
        accept      = 1'b0;
        if (va) begin
            if (fa) begin
                err_d  = (state_q == ACC);
                acc_d  = sat_val;
                sat_d  = clip;
                accept = 1'b1;
            end else if (state_q == ACC) begin
                acc_d  = sat_val;
                sat_d  = sat_q | clip;
                accept = 1'b1;
            end else begin
                err_d = 1'b1;
            end
            if (accept) begin
                if (la) begin
                    out_d       = sat_val;
                    out_valid_d = 1'b1;
                    ovf_d       = sat_d;
                    state_d     = IDLE;
                end else begin
                    state_d = ACC;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            sat_q       <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            sat_q       <= sat_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;
    assign err       = err_q;
    assign busy      = (state_q == ACC) | (|v_q);

endmodule
